// File: rtl/scc_wave.sv
// Konami SCC / SCC+ wavetable core: five voices with 32-byte wave RAM, 12-bit period
// counters and 4-bit volume, summed one channel per clock into a signed 16-bit sample.

module scc_wave_voice #(
  parameter int PERIOD_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                ld,
  input  logic [PERIOD_W-1:0] ld_val,
  input  logic [PERIOD_W-1:0] freq,
  output logic [4:0]          idx
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [4:0]          idx_q, idx_d;

  // A frequency write reloads the counter and suppresses any step on a coincident tick.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (ce && (freq >= PERIOD_W'(9))) begin
      if (cnt_q == '0) begin
        cnt_d = freq;
        idx_d = idx_q + 5'd1;
      end else begin
        cnt_d = cnt_q - PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;
endmodule

module scc_wave #(
  parameter int CHANNELS = 5,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        plus_mode,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic [15:0] sound,
  output logic        sound_valid
);
  localparam logic [2:0] NCH     = 3'(CHANNELS);
  localparam logic [4:0] PRESENT = 5'((1 << CHANNELS) - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  logic [4:0][31:0][7:0]     wave_q, wave_d;
  logic [4:0][PERIOD_W-1:0]  freq_q, freq_d;
  logic [4:0][VOL_W-1:0]     vol_q, vol_d;
  logic [4:0]                en_q, en_d;
  logic [4:0]                ld;
  logic [4:0][4:0]           idx;
  logic [7:0]                dout_q, dout_d;

  state_t                    state_q, state_d;
  logic [2:0]                ch_q, ch_d;
  logic signed [15:0]        acc_q, acc_d, sound_q, sound_d;
  logic                      valid_q, valid_d;

  // Address decode: wave window, then a 16-byte register block at 0x80 (SCC) or 0xA0 (SCC+).
  logic       wave_hit, wave_ok, reg_hit;
  logic [2:0] wave_ch, fch, vch;
  logic [4:0] wave_off;
  logic [3:0] reg_lo;
  logic       fhi;

  always_comb begin
    wave_ch  = addr[7:5];
    wave_off = addr[4:0];
    reg_lo   = addr[3:0];
    fch      = reg_lo[3:1];
    fhi      = reg_lo[0];
    vch      = 3'(reg_lo - 4'd10);
    if (plus_mode) begin
      wave_hit = addr < 8'hA0;
      reg_hit  = addr[7:4] == 4'hA;
    end else begin
      wave_hit = !addr[7];
      reg_hit  = addr[7:4] == 4'h8;
    end
    wave_ok = wave_hit && (wave_ch < NCH);
  end

  always_comb begin
    wave_d = wave_q;
    freq_d = freq_q;
    vol_d  = vol_q;
    en_d   = en_q;
    ld     = '0;
    if (wr) begin
      if (wave_ok) wave_d[wave_ch][wave_off] = din;
      if (reg_hit) begin
        if (reg_lo < 4'd10) begin
          if (fch < NCH) begin
            ld[fch] = 1'b1;
            if (fhi) freq_d[fch][PERIOD_W-1:8] = din[PERIOD_W-9:0];
            else     freq_d[fch][7:0]          = din;
          end
        end else if (reg_lo < 4'd15) begin
          if (vch < NCH) vol_d[vch] = din[VOL_W-1:0];
        end else begin
          en_d = din[4:0] & PRESENT;
        end
      end
    end
  end

  // Registers are write-only; only wave bytes of present channels read back.
  always_comb begin
    dout_d = dout_q;
    if (rd) dout_d = wave_ok ? wave_q[wave_ch][wave_off] : 8'hFF;
  end

  for (genvar i = 0; i < 5; i++) begin : g_ch
    scc_wave_voice #(.PERIOD_W(PERIOD_W)) u_voice (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .ld     (ld[i]),
      .ld_val (freq_d[i]),
      .freq   (freq_q[i]),
      .idx    (idx[i])
    );
  end

  // Mixer term for the channel under accumulation; ch4 borrows ch3's RAM in SCC mode.
  logic [2:0]         src;
  logic [7:0]         smp;
  logic signed [15:0] smp_s, vol_s, term;

  always_comb begin
    src   = (ch_q == 3'd4 && !plus_mode) ? 3'd3 : ch_q;
    smp   = wave_q[src][idx[ch_q]];
    smp_s = {{8{smp[7]}}, smp};
    vol_s = {{(16-VOL_W){1'b0}}, vol_q[ch_q]};
    term  = en_q[ch_q] ? smp_s * vol_s : '0;
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    sound_d = sound_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce) begin
          state_d = ACC;
          acc_d   = '0;
          ch_d    = '0;
        end
      end
      ACC: begin
        acc_d = acc_q + term;
        ch_d  = ch_q + 3'd1;
        if (ch_q == NCH - 3'd1) state_d = DONE;
      end
      DONE: begin
        sound_d = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wave_q  <= '0;
      freq_q  <= '0;
      vol_q   <= '0;
      en_q    <= '0;
      dout_q  <= 8'hFF;
      state_q <= IDLE;
      ch_q    <= '0;
      acc_q   <= '0;
      sound_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      vol_q   <= vol_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
    end
  end

  assign dout        = dout_q;
  assign sound       = sound_q;
  assign sound_valid = valid_q;
endmodule

// File: tb/tb_scc_wave.sv
// Bench for scc_wave: directed scenarios plus randomized traffic against a register-level
// model of the SCC; a second CHANNELS=3 instance checks the reduced build.

module tb_scc_wave;
  logic        clk = 1'b0, reset = 1'b1, ce = 1'b0, plus_mode = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0]  addr = '0, din = '0;
  logic [7:0]  dout, dout3;
  logic [15:0] sound, sound3;
  logic        sound_valid, sound_valid3;

  always #5 clk = ~clk;

  scc_wave dut (
    .clk(clk), .reset(reset), .ce(ce), .plus_mode(plus_mode), .addr(addr), .din(din),
    .wr(wr), .rd(rd), .dout(dout), .sound(sound), .sound_valid(sound_valid)
  );

  scc_wave #(.CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .ce(ce), .plus_mode(plus_mode), .addr(addr), .din(din),
    .wr(wr), .rd(rd), .dout(dout3), .sound(sound3), .sound_valid(sound_valid3)
  );

  // Reference model: register contents and per-voice phase as plain integers.
  int wv[5][32];
  int fr[5], vl[5], cnt[5], ix[5];
  int ms_en, cd, exp_sound, pend_sound;
  bit exp_valid;
  logic [7:0] exp_dout;
  int vectors = 0, miscompares = 0;

  function automatic int sb(input int b);
    return (b >= 128) ? b - 256 : b;
  endfunction

  function automatic int m_mix(input bit plus);
    int s = 0;
    for (int c = 0; c < 5; c++) begin
      int srcc = (c == 4 && !plus) ? 3 : c;
      if ((ms_en >> c) & 1) s += sb(wv[srcc][ix[c]]) * vl[c];
    end
    return s;
  endfunction

  task automatic m_decode(input int a, input bit plus, output int kind, output int ch, output int sub);
    int base;
    kind = 0; ch = 0; sub = 0;
    base = plus ? 160 : 128;
    if (a < base) begin kind = 1; ch = a / 32; sub = a % 32; end
    else if (a < base + 10) begin kind = 2; ch = (a - base) / 2; sub = (a - base) % 2; end
    else if (a < base + 15) begin kind = 3; ch = a - base - 10; end
    else if (a == base + 15) kind = 4;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive strobes, advance the model by the same edge, compare every output.
  task automatic clk1(input bit w, input bit r, input bit c, input int a, input int d);
    int kind, ch, sub, ldch;
    wr = w; rd = r; ce = c; addr = 8'(a); din = 8'(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; ce = 1'b0;
    exp_valid = 1'b0;
    if (reset) begin
      for (int k = 0; k < 5; k++) begin
        fr[k] = 0; vl[k] = 0; cnt[k] = 0; ix[k] = 0;
        for (int b = 0; b < 32; b++) wv[k][b] = 0;
      end
      ms_en = 0; cd = 0; exp_sound = 0; pend_sound = 0; exp_dout = 8'hFF;
    end else begin
      m_decode(a, plus_mode, kind, ch, sub);
      if (r) exp_dout = (kind == 1) ? 8'(wv[ch][sub]) : 8'hFF;
      ldch = (w && kind == 2) ? ch : -1;
      if (c)
        for (int k = 0; k < 5; k++)
          if (k != ldch && fr[k] >= 9) begin
            if (cnt[k] == 0) begin cnt[k] = fr[k]; ix[k] = (ix[k] + 1) % 32; end
            else cnt[k]--;
          end
      if (w)
        case (kind)
          1: wv[ch][sub] = d;
          2: begin
            if (sub == 1) fr[ch] = (fr[ch] & 255) | ((d & 15) << 8);
            else          fr[ch] = (fr[ch] & 'hF00) | d;
            cnt[ch] = fr[ch];
          end
          3: vl[ch] = d & 15;
          4: ms_en = d & 31;
          default: ;
        endcase
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin exp_valid = 1'b1; exp_sound = pend_sound; end
      end else if (c) begin
        cd = 6;
        pend_sound = m_mix(plus_mode);
      end
    end
    chk("sound_valid", 16'(sound_valid), 16'(exp_valid));
    chk("sound", sound, 16'(exp_sound));
    chk("dout", 16'(dout), 16'(exp_dout));
  endtask

  task automatic idle(input int n);
    repeat (n) clk1(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic wreg(input int a, input int d);
    clk1(1, 0, 0, a, d);
  endtask

  // Tick once and check the sample that emerges exactly six clocks later.
  task automatic ce_expect(input int v, input string tag);
    clk1(0, 0, 1, 0, 0);
    idle(6);
    chk({tag, "_valid"}, 16'(sound_valid), 16'h0001);
    chk(tag, sound, 16'(v));
    idle(1);
  endtask

  initial begin
    int prev, s, lat, r, a, d;
    bit wrap_seen;
    logic [15:0] snd3;

    do_reset();
    clk1(0, 1, 0, 8'h00, 0);
    chk("rst_rd00", 16'(dout), 16'h0000);
    clk1(0, 1, 0, 8'h80, 0);
    chk("rst_rd80", 16'(dout), 16'h00FF);
    chk("rst_sound", sound, 16'h0000);
    idle(4);

    // Single channel ramp, freq 9: index steps every 10 ticks and wraps 31 -> 0.
    for (int i = 0; i < 32; i++) wreg(i, i);
    wreg(8'h80, 9); wreg(8'h81, 0); wreg(8'h8A, 15); wreg(8'h8F, 1);
    prev = -1; wrap_seen = 1'b0;
    for (int n = 0; n < 330; n++) begin
      clk1(0, 0, 1, 0, 0);
      idle(6);
      s = int'($signed(sound));
      if (prev == 465 && s == 0) wrap_seen = 1'b1;
      prev = s;
      idle(1);
    end
    chk("wrap_465_to_0", 16'(wrap_seen), 16'h0001);

    // Ch4 shares ch3 RAM in SCC mode, then gets its own in SCC+.
    do_reset();
    wreg(8'h60, 8'h80); wreg(8'h8D, 15); wreg(8'h8E, 15); wreg(8'h8F, 8'h18);
    ce_expect(-3840, "shared");
    plus_mode = 1'b1;
    idle(1);
    wreg(8'h80, 8'h7F);
    ce_expect(-15, "plus_ch4");

    // Frozen below freq 9, then a freq write colliding with a tick.
    do_reset();
    plus_mode = 1'b0;
    for (int i = 0; i < 32; i++) wreg(i, i);
    wreg(8'h8A, 15); wreg(8'h8F, 1); wreg(8'h80, 8); wreg(8'h81, 0);
    for (int n = 0; n < 100; n++) ce_expect(0, "frozen");
    clk1(1, 0, 1, 8'h80, 9);
    idle(7);
    for (int n = 1; n < 10; n++) ce_expect(0, "post_load");
    ce_expect(15, "first_step");

    // Full negative scale on all five voices, then reset during accumulation.
    do_reset();
    plus_mode = 1'b1;
    idle(1);
    for (int c = 0; c < 5; c++) wreg(c * 32, 8'h80);
    for (int c = 0; c < 5; c++) wreg(8'hAA + c, 15);
    wreg(8'hAF, 8'h1F);
    ce_expect(-9600, "full_scale");
    chk("full_scale_hex", sound, 16'hDA80);
    clk1(0, 0, 1, 0, 0);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(8);
    chk("reset_mid_mix", sound, 16'h0000);

    // Randomized traffic against the model.
    do_reset();
    plus_mode = 1'b1;
    idle(1);
    for (int b = 0; b < 160; b++) wreg(b, $urandom_range(0, 255));
    for (int c = 0; c < 5; c++) wreg(8'hAA + c, $urandom_range(0, 15));
    for (int c = 0; c < 5; c++) begin
      wreg(8'hA0 + 2 * c, $urandom_range(9, 15));
      wreg(8'hA1 + 2 * c, 0);
    end
    wreg(8'hAF, 8'h1F);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (cd == 0 && r == 0) begin
        a = (plus_mode ? 160 : 128) + $urandom_range(0, 9);
        d = (a % 2 == 1) ? 0 : $urandom_range(0, 20);
        wreg(a, d);
      end else if (cd == 0 && r < 4) begin
        wreg($urandom_range(0, 255), $urandom_range(0, 255));
      end else if (cd == 0 && r == 4) begin
        plus_mode = 1'($urandom_range(0, 1));
        idle(1);
      end else if (r < 7) begin
        clk1(0, 1, 0, $urandom_range(0, 255), 0);
      end else if (cd == 0) begin
        clk1(1'($urandom_range(0, 1)), 0, 1, $urandom_range(0, 255), $urandom_range(0, 255));
      end else begin
        idle(1);
      end
    end
    idle(8);

    // Reduced build: ch3/ch4 registers are absent on the CHANNELS=3 instance.
    do_reset();
    plus_mode = 1'b0;
    idle(1);
    wreg(8'h00, 8'h10); wreg(8'h8A, 1); wreg(8'h8D, 15); wreg(8'h60, 8'h7F); wreg(8'h8F, 8'h19);
    clk1(0, 1, 0, 8'h60, 0);
    chk("ch3_rd_absent", 16'(dout3), 16'h00FF);
    clk1(0, 1, 0, 8'h00, 0);
    chk("ch0_rd_3ch", 16'(dout3), 16'h0010);
    idle(1);
    clk1(0, 0, 1, 0, 0);
    lat = 0; snd3 = '0;
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      if (sound_valid3 && lat == 0) begin lat = k; snd3 = sound3; end
    end
    chk("latency_3ch", 16'(lat), 16'd4);
    chk("sound_3ch", snd3, 16'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scc_wave.md
Name: scc_wave

Overview:
- Parametrised Konami SCC / SCC-I (SCC+) wavetable sound generator core.
- Sits behind the cartridge mapper's SCC register window and supplies the signed audio term that the scc device block sums into the machine mixer.
- Provides per-channel 32-byte waveform RAM, 12-bit period counters, 4-bit volume, an enable mask, and SCC/SCC+ register maps.
- Mixes channels sequentially into one signed 16-bit sample per sample tick.

Parameters:
- CHANNELS, 5, number of active voices, legal range 1..5. Registers of absent channels are ignored on write and read 0xFF.
- PERIOD_W, 12, period counter / frequency register width.
- VOL_W, 4, volume register width.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  sample tick (3.58 MHz enable), one clk wide. Spacing is at least CHANNELS+2 clks.
- plus_mode  in  1  0 = SCC map, 1 = SCC+ map. Sampled every cycle.
- addr  in  8  register offset within the SCC window.
- din  in  8  write data.
- wr  in  1  write strobe, one clk.
- rd  in  1  read strobe, one clk.
- dout  out  8  read data, valid the clk after rd, held until the next rd.
- sound  out  16  signed mixed sample.
- sound_valid  out  1  one-clk pulse when sound updates.

Behaviour:
- Reset:
  - All wave RAM bytes, freq, vol, enable, counters and wave indices are 0.
  - sound = 0, sound_valid = 0, dout = 0xFF, mixer FSM = IDLE.
  - Reset mid-mix aborts the accumulation; sound keeps 0.
- SCC map (plus_mode=0):
  - 0x00-0x7F: wave ch0-3, 32 B each. Ch4 plays ch3's RAM.
  - 0x80-0x89: freq, 2 B per channel (even = low 8 bits, odd = high 4 bits in din[3:0]).
  - 0x8A-0x8E: vol in din[3:0].
  - 0x8F: enable mask in din[4:0].
  - 0x90-0xFF: no effect.
- SCC+ map (plus_mode=1):
  - 0x00-0x9F: wave ch0-4; ch4 has its own RAM.
  - 0xA0-0xA9: freq.
  - 0xAA-0xAE: vol.
  - 0xAF: enable mask.
  - Others: no effect.
- Mode switch retains all storage; only decode and ch4 wave source change.
- Reads:
  - Wave addresses return the RAM byte.
  - freq/vol/enable/unmapped addresses return 0xFF (write-only registers).
  - Latency is 1 clk.
- Period counter, per channel, on ce:
  - If freq < 9: counter and index hold (channel frozen; it still mixes its current sample).
  - Else if counter == 0: counter <= freq and index <= index+1 mod 32 (wraps 31 -> 0).
  - Else counter decrements.
  - Step period is therefore freq+1 ticks.
- Freq write (either byte) loads counter with the new full freq value. The index is not changed.
- Freq write in the same clk as ce: the write wins, the counter loads the new value, and the index does not advance on that tick.
- Wave write in the same clk as a mixer read of that byte: the mixer sees the old byte; the new byte is visible the next clk.
- Mixer FSM:
  - IDLE: on ce, go to ACC with acc = 0 and ch = 0.
  - ACC: one channel per clk. term = enable[ch] ? signed8(wave[ch][index]) * vol : 0, giving a signed 12-bit term. acc (signed 16) += term. Advance to DONE after ch = CHANNELS-1.
  - DONE: sound <= acc, sound_valid <= 1 for 1 clk, then return to IDLE.
  - Latency from ce to sound_valid is CHANNELS+1 clks.
  - ce arriving while not IDLE is ignored by the mixer; counters still step.
- Range: worst case 5 * (-128 * 15) = -9600, so no overflow and no saturation is needed.

Test Plan:
- Reset, then rd at 0x00 and at 0x80 -> dout 0x00 and 0xFF respectively. sound = 0. No sound_valid until the first ce.
- SCC mode, single channel:
  - Stimulus: ch0 wave bytes 0x00..0x1F, freq = 9, vol = 15, enable = 0x01, ce every 8 clks.
  - Required: index advances every 10 ce. sound = 15 × index. sound_valid arrives CHANNELS+1 = 6 clks after each ce. The index wraps 31 -> 0, giving sound 465 then 0.
- SCC mode, shared wave:
  - Stimulus: write 0x80 at 0x60, then vol3 = vol4 = 15, enable = 0x18.
  - Required: sound = -3840.
  - Then switch plus_mode = 1 and write 0x7F at 0x80 (ch4 RAM byte 0) -> sound = -1920 + 1905 = -15.
- Freq < 9:
  - Stimulus: set freq = 8 and run 100 ce.
  - Required: index is unchanged and sound is constant.
  - Then write freq = 9 in the same clk as a ce: no index step on that tick; the first step comes 10 ticks later.
- Full scale:
  - Stimulus: all 5 channels have wave = 0x80, vol = 15, enable = 0x1F (SCC+).
  - Required: sound = -9600 (0xDA80) with no wrap.
  - Assert reset during ACC -> sound = 0 and no sound_valid pulse.
- CHANNELS=3 build:
  - Stimulus: write vol to 0x8D, enable ch3/4 in the mask.
  - Required: no contribution, rd of ch3 wave returns 0xFF, and sound_valid comes 4 clks after ce.
